// File: rtl/lagd_fifo_v4.sv
// Synchronous FIFO with per-entry bubble flags, optional fall-through, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module lagd_fifo_v4 #(
  parameter int unsigned FALL_THROUGH = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned RESET_VALUE  = 0,
  parameter int unsigned AW           = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  push_none_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  none_o,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [AW:0]           af_thresh_i,
  input  logic [AW:0]           ae_thresh_i,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [AW:0]           usage_o,
  input  logic                  clr_err_i,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [DATA_WIDTH-1:0] RST_PATTERN =
    (RESET_VALUE != 0) ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : '0;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH-1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      bubble_q, bubble_d;
  logic [AW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;

  logic cnt_zero, ft_active, push_acc, pop_acc, bypass, wr_en, rd_en;

  assign cnt_zero  = (count_q == '0);
  assign ft_active = (FALL_THROUGH != 0) && cnt_zero && push_i;
  assign full_o    = (count_q == DEPTH_W);
  assign empty_o   = cnt_zero && !ft_active;
  assign push_acc  = push_i && !full_o && !flush_i;
  assign pop_acc   = pop_i && !empty_o && !flush_i;
  // Fall-through push consumed by a same-cycle pop never touches storage.
  assign bypass    = ft_active && pop_acc;
  assign wr_en     = push_acc && !bypass;
  assign rd_en     = pop_acc && !bypass;

  assign data_o         = ft_active ? data_i : mem_q[rptr_q];
  assign none_o         = ft_active ? push_none_i : bubble_q[rptr_q];
  assign usage_o        = count_q;
  assign almost_full_o  = (count_q >= af_thresh_i);
  assign almost_empty_o = (count_q <= ae_thresh_i);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  always_comb begin
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    bubble_d    = bubble_q;
    overflow_d  = (overflow_q && !clr_err_i) || (push_i && full_o && !flush_i);
    underflow_d = (underflow_q && !clr_err_i) || (pop_i && empty_o && !flush_i);
    if (flush_i) begin
      rptr_d   = '0;
      wptr_d   = '0;
      count_d  = '0;
      bubble_d = '0;
    end else begin
      if (wr_en) begin
        bubble_d[wptr_q] = push_none_i;
        wptr_d = (wptr_q == PTR_MAX) ? '0 : wptr_q + AW'(1);
      end
      if (rd_en) begin
        rptr_d = (rptr_q == PTR_MAX) ? '0 : rptr_q + AW'(1);
      end
      if (wr_en && !rd_en) begin
        count_d = count_q + (AW+1)'(1);
      end else if (rd_en && !wr_en) begin
        count_d = count_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      bubble_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      bubble_q    <= bubble_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Bubble pushes leave the slot's old data in place.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_PATTERN;
    end else if (wr_en && !push_none_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: tb/tb_lagd_fifo_v4.sv
// Scoreboard bench for lagd_fifo_v4: a DEPTH=4 plain FIFO and a DEPTH=5
// fall-through FIFO with the max-positive reset pattern.
module tb_lagd_fifo_v4;

  typedef struct packed {
    logic [7:0] d;
    logic       n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: DEPTH=4, FALL_THROUGH=0, RESET_VALUE=0
  logic       rst_a_n, flush_a, push_a, none_in_a, pop_a, clr_a;
  logic [7:0] din_a, dout_a;
  logic       none_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [2:0] af_th_a, ae_th_a, usage_a;

  // Instance B: DEPTH=5, FALL_THROUGH=1, RESET_VALUE=1
  logic       rst_b_n, flush_b, push_b, none_in_b, pop_b, clr_b;
  logic [7:0] din_b, dout_b;
  logic       none_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [3:0] af_th_b, ae_th_b, usage_b;

  lagd_fifo_v4 #(.FALL_THROUGH(0), .DATA_WIDTH(8), .DEPTH(4), .RESET_VALUE(0)) u_a (
    .clk_i(clk), .rst_ni(rst_a_n), .flush_i(flush_a), .push_i(push_a),
    .push_none_i(none_in_a), .data_i(din_a), .pop_i(pop_a), .data_o(dout_a),
    .none_o(none_a), .full_o(full_a), .empty_o(empty_a), .af_thresh_i(af_th_a),
    .ae_thresh_i(ae_th_a), .almost_full_o(af_a), .almost_empty_o(ae_a),
    .usage_o(usage_a), .clr_err_i(clr_a), .overflow_o(ovf_a), .underflow_o(unf_a)
  );

  lagd_fifo_v4 #(.FALL_THROUGH(1), .DATA_WIDTH(8), .DEPTH(5), .RESET_VALUE(1)) u_b (
    .clk_i(clk), .rst_ni(rst_b_n), .flush_i(flush_b), .push_i(push_b),
    .push_none_i(none_in_b), .data_i(din_b), .pop_i(pop_b), .data_o(dout_b),
    .none_o(none_b), .full_o(full_b), .empty_o(empty_b), .af_thresh_i(af_th_b),
    .ae_thresh_i(ae_th_b), .almost_full_o(af_b), .almost_empty_o(ae_b),
    .usage_o(usage_b), .clr_err_i(clr_b), .overflow_o(ovf_b), .underflow_o(unf_b)
  );

  exp_t exp_a[$];
  exp_t exp_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: whenever a pop will be accepted on the next edge, compare the head.
  always @(negedge clk) begin
    if (rst_a_n && pop_a && !empty_a && !flush_a) begin
      if (exp_a.size() == 0) begin
        chk("sb_a_unexpected_pop", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_a.pop_front();
        chk("sb_a_none", {31'd0, none_a}, {31'd0, e.n});
        if (!e.n) chk("sb_a_data", {24'd0, dout_a}, {24'd0, e.d});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b_n && pop_b && !empty_b && !flush_b) begin
      if (exp_b.size() == 0) begin
        chk("sb_b_unexpected_pop", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_b.pop_front();
        chk("sb_b_none", {31'd0, none_b}, {31'd0, e.n});
        if (!e.n) chk("sb_b_data", {24'd0, dout_b}, {24'd0, e.d});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [0:4] ae_tab;
  logic [0:4] af_tab;

  initial begin
    ae_tab = 5'b11000;
    af_tab = 5'b00011;
    rst_a_n = 0; flush_a = 0; push_a = 0; none_in_a = 0; pop_a = 0; clr_a = 0; din_a = 0;
    rst_b_n = 0; flush_b = 0; push_b = 0; none_in_b = 0; pop_b = 0; clr_b = 0; din_b = 0;
    af_th_a = 3'd3; ae_th_a = 3'd1;
    af_th_b = 4'd0; ae_th_b = 4'd0;
    tick(); tick();

    // Reset state
    chk("rst_a_usage", 32'(usage_a), 0);
    chk("rst_a_full", 32'(full_a), 0);
    chk("rst_a_empty", 32'(empty_a), 1);
    chk("rst_a_none", 32'(none_a), 0);
    chk("rst_a_ovf", 32'(ovf_a), 0);
    chk("rst_a_unf", 32'(unf_a), 0);
    chk("rst_a_ae", 32'(ae_a), 1);
    chk("rst_a_af", 32'(af_a), 0);
    chk("rst_a_data", 32'(dout_a), 32'h00);
    chk("rst_b_data", 32'(dout_b), 32'h7F);
    chk("rst_b_af_thresh0", 32'(af_b), 1);
    rst_a_n = 1; rst_b_n = 1;
    tick();

    // Fill A with thresholds checked at each occupancy
    chk("thr_ae_u0", 32'(ae_a), 32'(ae_tab[0]));
    chk("thr_af_u0", 32'(af_a), 32'(af_tab[0]));
    for (int i = 0; i < 4; i++) begin
      push_a = 1; din_a = 8'hA1 + 8'(i);
      exp_a.push_back('{d: 8'hA1 + 8'(i), n: 1'b0});
      tick();
      chk("fill_usage", 32'(usage_a), 32'(i + 1));
      chk("thr_ae", 32'(ae_a), 32'(ae_tab[i+1]));
      chk("thr_af", 32'(af_a), 32'(af_tab[i+1]));
    end
    push_a = 0;
    chk("fill_full", 32'(full_a), 1);

    // Overflow: push into full FIFO is dropped
    push_a = 1; din_a = 8'hEE;
    tick();
    push_a = 0;
    chk("ovf_set", 32'(ovf_a), 1);
    chk("ovf_usage", 32'(usage_a), 4);

    // Drain, scoreboard checks A1..A4
    pop_a = 1;
    repeat (4) tick();
    pop_a = 0;
    chk("drain_empty", 32'(empty_a), 1);
    chk("drain_usage", 32'(usage_a), 0);

    // Underflow and clear
    pop_a = 1;
    tick();
    pop_a = 0;
    chk("unf_set", 32'(unf_a), 1);
    chk("ovf_sticky", 32'(ovf_a), 1);
    clr_a = 1;
    tick();
    clr_a = 0;
    chk("clr_ovf", 32'(ovf_a), 0);
    chk("clr_unf", 32'(unf_a), 0);

    // Flush while full with push and pop held: no error, everything cleared
    for (int i = 0; i < 4; i++) begin
      push_a = 1; din_a = 8'hC0 + 8'(i);
      tick();
    end
    push_a = 1; pop_a = 1; flush_a = 1; din_a = 8'hDD;
    tick();
    push_a = 0; pop_a = 0; flush_a = 0;
    chk("flush_usage", 32'(usage_a), 0);
    chk("flush_empty", 32'(empty_a), 1);
    chk("flush_ovf", 32'(ovf_a), 0);
    chk("flush_unf", 32'(unf_a), 0);

    // Bubbles
    push_a = 1; din_a = 8'h11; none_in_a = 0;
    exp_a.push_back('{d: 8'h11, n: 1'b0});
    tick();
    din_a = 8'hFF; none_in_a = 1;
    exp_a.push_back('{d: 8'hFF, n: 1'b1});
    tick();
    din_a = 8'h33; none_in_a = 0;
    exp_a.push_back('{d: 8'h33, n: 1'b0});
    tick();
    push_a = 0;
    chk("bub_usage", 32'(usage_a), 3);
    pop_a = 1;
    repeat (3) tick();
    pop_a = 0;
    chk("bub_empty", 32'(empty_a), 1);

    // B: fall-through push+pop when empty
    push_b = 1; pop_b = 1; din_b = 8'h5A;
    exp_b.push_back('{d: 8'h5A, n: 1'b0});
    #1;
    chk("ft_data", 32'(dout_b), 32'h5A);
    chk("ft_empty", 32'(empty_b), 0);
    tick();
    push_b = 0; pop_b = 0;
    #1;
    chk("ft_usage", 32'(usage_b), 0);
    chk("ft_empty_after", 32'(empty_b), 1);
    chk("ft_unf", 32'(unf_b), 0);

    // B: non-power-of-two wrap with occupancy held at 3
    for (int i = 0; i < 3; i++) begin
      push_b = 1; din_b = 8'h30 + 8'(i);
      exp_b.push_back('{d: 8'h30 + 8'(i), n: 1'b0});
      tick();
    end
    pop_b = 1;
    for (int i = 0; i < 12; i++) begin
      din_b = 8'h40 + 8'(i);
      exp_b.push_back('{d: 8'h40 + 8'(i), n: 1'b0});
      tick();
      chk("wrap_usage", 32'(usage_b), 3);
    end
    push_b = 0;
    repeat (3) tick();
    pop_b = 0;
    chk("wrap_drained", 32'(usage_b), 0);

    // B: reset mid-fill
    push_b = 1; din_b = 8'h61;
    tick();
    din_b = 8'h62;
    tick();
    chk("midfill_usage", 32'(usage_b), 2);
    push_b = 0; rst_b_n = 0;
    #1;
    chk("rst_mid_usage", 32'(usage_b), 0);
    chk("rst_mid_empty", 32'(empty_b), 1);
    chk("rst_mid_data", 32'(dout_b), 32'h7F);
    tick();
    rst_b_n = 1;
    tick();

    chk("sb_a_left", 32'(exp_a.size()), 0);
    chk("sb_b_left", 32'(exp_b.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
